// File: rtl/ysyx_201979054_axi_burst_responder.sv
// AXI4-Lite responder backed by a word-addressed memory, serving cache-line refills and
// write-backs one beat at a time and flagging each completed line per direction.
module ysyx_201979054_axi_burst_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0,
  parameter int                    BURST_LEN  = 16
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic                    i_restartn,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic                    o_rd_burst_done,
  output logic                    o_wr_burst_done
);
  localparam int LSB = $clog2(DATA_WIDTH / 8);
  localparam int IW  = $clog2(MEM_DEPTH);
  localparam int CW  = $clog2(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [CW-1:0]         LAST_CNT = CW'(BURST_LEN - 1);
  localparam logic [1:0]            OKAY     = 2'b00;
  localparam logic [1:0]            SLVERR   = 2'b10;

  // Handshake rule: a transfer happens on a rising edge where valid and ready are both 1;
  // valid outputs and their payload stay stable until that edge.
  typedef enum logic [1:0] {IDLE, RD_RESP, WR_RESP} state_t;
  typedef enum logic {GRANT_RD, GRANT_WR} grant_t;

  state_t state, state_next;
  grant_t last_grant;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] ar_word, aw_word;
  logic                  ar_ok, aw_ok;
  logic [IW-1:0]         ar_idx, aw_idx;
  logic                  rd_req, wr_req, grant_rd, grant_wr;
  logic                  ar_hs, aw_hs, r_hs, b_hs;
  logic [CW-1:0]         rd_cnt, wr_cnt;

  always_comb begin
    ar_word = (s_araddr - BASE_ADDR) >> LSB;
    aw_word = (s_awaddr - BASE_ADDR) >> LSB;
    ar_ok   = (s_araddr >= BASE_ADDR) && (ar_word < DEPTH_A);
    aw_ok   = (s_awaddr >= BASE_ADDR) && (aw_word < DEPTH_A);
    ar_idx  = ar_word[IW-1:0];
    aw_idx  = aw_word[IW-1:0];
  end

  // A tie goes to whichever direction was not served last.
  always_comb begin
    rd_req   = s_arvalid;
    wr_req   = s_awvalid & s_wvalid;
    grant_rd = rd_req & (~wr_req | (last_grant == GRANT_WR));
    grant_wr = wr_req & (~rd_req | (last_grant == GRANT_RD));
  end

  always_comb begin
    state_next = state;
    s_arready  = 1'b0;
    s_awready  = 1'b0;
    s_wready   = 1'b0;
    case (state)
      IDLE: begin
        if (!arst) begin
          s_arready = grant_rd;
          s_awready = grant_wr;
          s_wready  = grant_wr;
        end
        if (grant_rd)      state_next = RD_RESP;
        else if (grant_wr) state_next = WR_RESP;
      end
      RD_RESP: if (s_rready) state_next = IDLE;
      WR_RESP: if (s_bready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign s_rvalid = (state == RD_RESP);
  assign s_bvalid = (state == WR_RESP);
  assign ar_hs    = s_arready;
  assign aw_hs    = s_awready;
  assign r_hs     = s_rvalid & s_rready;
  assign b_hs     = s_bvalid & s_bready;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= IDLE;
      last_grant <= GRANT_WR;
      s_rdata    <= '0;
      s_rresp    <= OKAY;
      s_bresp    <= OKAY;
    end else begin
      state <= state_next;
      if (ar_hs) begin
        s_rdata    <= ar_ok ? mem[ar_idx] : '0;
        s_rresp    <= ar_ok ? OKAY : SLVERR;
        last_grant <= GRANT_RD;
      end else if (aw_hs) begin
        s_bresp    <= aw_ok ? OKAY : SLVERR;
        last_grant <= GRANT_WR;
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (aw_hs && aw_ok) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (s_wstrb[b]) mem[aw_idx][b*8 +: 8] <= s_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rd_cnt          <= '0;
      wr_cnt          <= '0;
      o_rd_burst_done <= 1'b0;
      o_wr_burst_done <= 1'b0;
    end else if (!i_restartn) begin
      rd_cnt          <= '0;
      wr_cnt          <= '0;
      o_rd_burst_done <= 1'b0;
      o_wr_burst_done <= 1'b0;
    end else begin
      o_rd_burst_done <= r_hs && (rd_cnt == LAST_CNT);
      o_wr_burst_done <= b_hs && (wr_cnt == LAST_CNT);
      if (r_hs) rd_cnt <= rd_cnt + 1'b1;
      if (b_hs) wr_cnt <= wr_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ysyx_201979054_axi_burst_responder.sv
// Self-checking bench for the AXI4-Lite burst responder: vector table plus hand-written
// sequences for reset, arbitration, backpressure and beat counting.
module tb_ysyx_201979054_axi_burst_responder;
  logic        clk = 1'b0;
  logic        arst;
  logic        i_restartn;
  logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_rresp, s_bresp;
  logic        o_rd_burst_done, o_wr_burst_done;

  ysyx_201979054_axi_burst_responder dut (
    .clk(clk), .arst(arst), .i_restartn(i_restartn),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .o_rd_burst_done(o_rd_burst_done), .o_wr_burst_done(o_wr_burst_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int rd_pulses = 0;
  int wr_pulses = 0;
  logic [33:0] exp_rd_q[$];
  logic [1:0]  exp_b_q[$];
  logic [33:0] mon_e;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // scoreboard: pop on every R/B handshake
  always @(negedge clk) begin
    if (!arst) begin
      if (s_rvalid && s_rready) begin
        if (exp_rd_q.size() == 0) check("r_unexpected", 1, 0);
        else begin
          mon_e = exp_rd_q.pop_front();
          check("r_data", s_rdata, mon_e[31:0]);
          check("r_resp", s_rresp, mon_e[33:32]);
        end
      end
      if (s_bvalid && s_bready) begin
        if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
        else check("b_resp", s_bresp, exp_b_q.pop_front());
      end
      if (o_rd_burst_done) rd_pulses++;
      if (o_wr_burst_done) wr_pulses++;
    end
  end

  // driver tasks: called and returning at posedge+1
  task automatic apply_reset();
    arst = 1'b1; i_restartn = 1'b1;
    s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0;
    exp_rd_q.delete(); exp_b_q.delete();
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] ed, input logic [1:0] er);
    int n;
    exp_rd_q.push_back({er, ed});
    s_araddr = addr; s_arvalid = 1'b1; n = 0;
    @(negedge clk);
    while (!s_arready && n < 100) begin n++; @(negedge clk); end
    if (!s_arready) begin check("ar_timeout", 0, 1); s_arvalid = 1'b0; return; end
    @(posedge clk); #1 s_arvalid = 1'b0;
    check("rvalid_latency", s_rvalid, 1);
    s_rready = 1'b1; n = 0;
    @(negedge clk);
    while (!s_rvalid && n < 100) begin n++; @(negedge clk); end
    if (!s_rvalid) check("r_timeout", 0, 1);
    @(posedge clk); #1 s_rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] strb,
                          input logic [1:0] er);
    int n;
    exp_b_q.push_back(er);
    s_awaddr = addr; s_wdata = d; s_wstrb = strb; s_awvalid = 1'b1; s_wvalid = 1'b1; n = 0;
    @(negedge clk);
    while (!s_awready && n < 100) begin n++; @(negedge clk); end
    if (!s_awready) begin check("aw_timeout", 0, 1); s_awvalid = 1'b0; s_wvalid = 1'b0; return; end
    check("wready_with_awready", s_wready, 1);
    @(posedge clk); #1 s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("bvalid_latency", s_bvalid, 1);
    s_bready = 1'b1; n = 0;
    @(negedge clk);
    while (!s_bvalid && n < 100) begin n++; @(negedge clk); end
    if (!s_bvalid) check("b_timeout", 0, 1);
    @(posedge clk); #1 s_bready = 1'b0;
  endtask

  task automatic restart();
    i_restartn = 1'b0;
    @(posedge clk); #1 i_restartn = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF,    32'h0,        2'b00};
    vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'h0,    32'hDEADBEEF, 2'b00};
    vecs[2]  = '{1'b1, 32'h10,       32'h11223344, 4'b0101, 32'h0,        2'b00};
    vecs[3]  = '{1'b0, 32'h10,       32'h0,        4'h0,    32'hDE22BE44, 2'b00};
    vecs[4]  = '{1'b1, 32'h0,        32'hCAFEF00D, 4'hF,    32'h0,        2'b00};
    vecs[5]  = '{1'b1, 32'h1000,     32'h12345678, 4'hF,    32'h0,        2'b10};
    vecs[6]  = '{1'b0, 32'h1000,     32'h0,        4'h0,    32'h0,        2'b10};
    vecs[7]  = '{1'b0, 32'h0,        32'h0,        4'h0,    32'hCAFEF00D, 2'b00};
    vecs[8]  = '{1'b0, 32'h13,       32'h0,        4'h0,    32'hDE22BE44, 2'b00};
    vecs[9]  = '{1'b1, 32'hFFC,      32'hA5A5A5A5, 4'hF,    32'h0,        2'b00};
    vecs[10] = '{1'b0, 32'hFFC,      32'h0,        4'h0,    32'hA5A5A5A5, 2'b00};
    vecs[11] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0,    32'h0,        2'b10};

    apply_reset();
    check("rst_rvalid", s_rvalid, 0);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_arready", s_arready, 0);
    check("rst_rdata", s_rdata, 0);
    check("rst_rresp", s_rresp, 0);
    check("rst_bresp", s_bresp, 0);
    check("rst_done", {o_rd_burst_done, o_wr_burst_done}, 0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].exp_resp);
      else            do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
    end

    // reset in the middle of a read response
    s_araddr = 32'h10; s_arvalid = 1'b1;
    @(negedge clk); check("mid_arready", s_arready, 1);
    @(posedge clk); #1 s_arvalid = 1'b0;
    check("mid_rvalid", s_rvalid, 1);
    #2 arst = 1'b1;
    #1;
    check("arst_rvalid", s_rvalid, 0);
    check("arst_rresp", s_rresp, 0);
    check("arst_rdata", s_rdata, 0);
    check("arst_readies", {s_arready, s_awready, s_wready, s_bvalid}, 0);
    check("arst_done", {o_rd_burst_done, o_wr_burst_done}, 0);
    @(posedge clk); #1 arst = 1'b0;
    @(posedge clk); #1;
    do_read(32'h10, 32'hDE22BE44, 2'b00);

    // same-cycle read and write after reset: read first, held under backpressure
    apply_reset();
    exp_rd_q.push_back({2'b00, 32'hDE22BE44});
    exp_b_q.push_back(2'b00);
    s_araddr = 32'h10; s_arvalid = 1'b1;
    s_awaddr = 32'h20; s_wdata = 32'h0BADF00D; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge clk);
    check("tie_arready", s_arready, 1);
    check("tie_awready", {s_awready, s_wready}, 0);
    @(posedge clk); #1 s_arvalid = 1'b0;
    check("tie_rvalid", s_rvalid, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_rvalid", s_rvalid, 1);
      check("hold_rdata", s_rdata, 32'hDE22BE44);
      check("hold_rresp", s_rresp, 0);
      check("hold_awready", s_awready, 0);
    end
    @(posedge clk); #1 s_rready = 1'b1;
    @(posedge clk); #1 s_rready = 1'b0;
    check("tie_back_idle", s_rvalid, 0);
    @(negedge clk);
    check("tie_wr_grant", {s_awready, s_wready, s_arready}, 3'b110);
    @(posedge clk); #1 s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("tie_bvalid", s_bvalid, 1);
    s_bready = 1'b1;
    @(posedge clk); #1 s_bready = 1'b0;
    do_read(32'h20, 32'h0BADF00D, 2'b00);

    // read beat counting and restart
    restart();
    p0 = rd_pulses;
    for (int i = 0; i < 16; i++) begin
      do_read(32'h10, 32'hDE22BE44, 2'b00);
      if (i == 14) check("rd_done_early", o_rd_burst_done, 0);
    end
    check("rd_done_pulse", o_rd_burst_done, 1);
    @(posedge clk); #1;
    check("rd_done_width", o_rd_burst_done, 0);
    check("rd_pulse_count", rd_pulses, p0 + 1);
    for (int i = 0; i < 8; i++) do_read(32'h10, 32'hDE22BE44, 2'b00);
    restart();
    for (int i = 0; i < 15; i++) do_read(32'h10, 32'hDE22BE44, 2'b00);
    check("rd_no_pulse_after_restart", rd_pulses, p0 + 1);
    do_read(32'h10, 32'hDE22BE44, 2'b00);
    check("rd_done_after_restart", o_rd_burst_done, 1);

    // write beat counting
    restart();
    p0 = wr_pulses;
    for (int i = 0; i < 16; i++) begin
      do_write(32'h100 + 32'(4 * i), 32'(i) * 32'h01010101, 4'hF, 2'b00);
      if (i == 14) check("wr_done_early", o_wr_burst_done, 0);
    end
    check("wr_done_pulse", o_wr_burst_done, 1);
    @(posedge clk); #1;
    check("wr_pulse_count", wr_pulses, p0 + 1);
    do_read(32'h114, 32'h05050505, 2'b00);

    check("rd_queue_empty", exp_rd_q.size(), 0);
    check("b_queue_empty", exp_b_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
